player_move_cmd_gen: RTL
========================

// Module: player_move_cmd_gen
// PURPOSE
//  Source end of the player movement-command interface: turns PS/2 keyboard scan bytes into the
//  forward / rotate strobes consumed by the player position register. Tracks make/break state of
//  movement keys and issues one-cycle command pulses on game ticks while keys are held.
//  Sits between the PS/2 byte receiver and the player state register.
// PARAMETERS
//  TICK_DIV    default 1      game ticks per command pulse (1..255); 1 = pulse every tick
//  IDLE_TICKS  default 600    ticks with no scan byte before held keys auto-clear (macro only)
// PORTS
//  clk          in   1  system clock
//  resetn       in   1  asynchronous active-low reset
//  scan_code    in   8  PS/2 scan byte from receiver
//  scan_valid   in   1  one-cycle strobe, scan_code valid
//  tick         in   1  one-cycle game-frame strobe
//  forward      out  1  one-cycle move-forward command
//  rotate       out  1  one-cycle rotate command
//  rotate_ccw   out  1  direction qualifier for rotate (1 = left/CCW); valid when rotate=1
//  keys_held    out  3  {rot_right, rot_left, fwd} current held state
// BEHAVIOUR
//  Reset (async, resetn=0): all outputs 0, decoder state IDLE, held=0, tick divider=0.
//  Decoder FSM, advances only on scan_valid:
//   IDLE   : E0->EXT; F0->BRK; other->apply make(code,ext=0), stay IDLE
//   EXT    : F0->EXT_BRK; other->apply make(code,ext=1), ->IDLE
//   BRK    : any->apply break(code,ext=0), ->IDLE
//   EXT_BRK: any->apply break(code,ext=1), ->IDLE
//   E1 or unmapped codes: no held change; FSM follows rules above (E1 acts as plain byte).
//  Key map: fwd = {E0 75} or {1D}; rot_left = {E0 6B} or {1C}; rot_right = {E0 74} or {23}.
//   Non-extended 75/6B/74 (keypad) unmapped. Make sets bit, break clears; repeats idempotent.
//   Either alias sets/clears the same bit (no per-alias tracking).
//  keys_held registered: scan byte at cycle N visible at N+1.
//  Tick divider: counts ticks 0..TICK_DIV-1; fire on tick when count==TICK_DIV-1, then wrap to 0.
//  On fire cycle T, outputs registered at T+1, high exactly one cycle:
//   forward = fwd; rotate = rot_left XOR rot_right; rotate_ccw = rot_left & ~rot_right.
//   Both rotate keys held -> rotate=0, rotate_ccw=0. No fire -> all strobes 0.
//  scan_valid and tick same cycle: fire samples held state BEFORE that byte is applied.
//  Reset mid-sequence (e.g. after E0): prefix discarded; next byte decoded from IDLE.
//  forward and rotate may pulse in the same cycle.
// CONFIGURATION
//  PLAYER_MOVE_IDLE_CLR_EN defined: tick counter of ticks since last scan_valid (saturating);
//   when it reaches IDLE_TICKS with any key held, held cleared next cycle (lost-break guard);
//   counter zeroed on every scan_valid and on reset.
//  Not defined: held keys persist until explicit break; IDLE_TICKS ignored, no counter logic.
// STRUCTURE
//  Package player_input_pkg: scan-code constants (E0, F0, key codes), decoder state enum,
//   key-bit index constants for keys_held.
//  Sub-module player_key_decoder: prefix FSM -> {key_evt_valid, ext, release, code}.
//  Top: key map, held register, tick divider, strobe generation, optional idle-clear counter.
// TESTING
//  Reset: hold resetn=0, drive tick/scan_valid -> all outputs 0; release -> still 0 until keys.
//  E0,75 then 3 ticks (TICK_DIV=1) -> 3 forward pulses, 1 cycle each, T+1; E0,F0,75 then tick -> none.
//  1C held, tick -> rotate=1, rotate_ccw=1; add 23, tick -> rotate=0; F0,1C, tick -> rotate=1, ccw=0.
//  Unmapped 55, F0 55, E0 F0 6B with nothing held -> keys_held stays 000, no pulses.
//  1D with scan_valid and tick same cycle -> no pulse that tick; next tick -> forward pulse.
//  E0 then resetn pulse, then 75 -> keys_held 000 (keypad 8 unmapped); TICK_DIV=3 -> pulse every 3rd tick.
//  With PLAYER_MOVE_IDLE_CLR_EN, IDLE_TICKS=4: 1D, 4 ticks no bytes -> keys_held clears, pulses stop.

Source files
------------

// File: rtl/player_input_pkg.sv
// player_input_pkg: scan-code constants, decoder states and key-bit indices for the player input path
package player_input_pkg;
    localparam logic [7:0] SC_E0       = 8'hE0;
    localparam logic [7:0] SC_F0       = 8'hF0;
    localparam logic [7:0] SC_FWD      = 8'h1D;
    localparam logic [7:0] SC_ROTL     = 8'h1C;
    localparam logic [7:0] SC_ROTR     = 8'h23;
    localparam logic [7:0] SC_FWD_EXT  = 8'h75;
    localparam logic [7:0] SC_ROTL_EXT = 8'h6B;
    localparam logic [7:0] SC_ROTR_EXT = 8'h74;
    localparam int KEY_FWD  = 0;
    localparam int KEY_ROTL = 1;
    localparam int KEY_ROTR = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} dec_state_t;
    // One-hot {rot_right, rot_left, fwd} for a decoded key; keypad codes without E0 map to nothing
    function automatic logic [2:0] key_mask(input logic ext, input logic [7:0] code);
        return {code == (ext ? SC_ROTR_EXT : SC_ROTR),
                code == (ext ? SC_ROTL_EXT : SC_ROTL),
                code == (ext ? SC_FWD_EXT  : SC_FWD)};
    endfunction
endpackage

// File: rtl/player_key_decoder.sv
// player_key_decoder: PS/2 E0/F0 prefix tracker emitting one key event per complete scan sequence
module player_key_decoder
    import player_input_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic       evt_valid,
    output logic       evt_ext,
    output logic       evt_brk,
    output logic [7:0] evt_code
);
    dec_state_t state, state_nxt;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            state <= ST_IDLE;
        else if (scan_valid)
            state <= state_nxt;
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: state_nxt = scan_code == SC_E0 ? ST_EXT : scan_code == SC_F0 ? ST_BRK : ST_IDLE;
            ST_EXT:  state_nxt = scan_code == SC_F0 ? ST_EXT_BRK : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end
    // Any byte that returns the FSM to IDLE completes a sequence; prefixes move it elsewhere
    always_comb begin
        evt_valid = scan_valid && state_nxt == ST_IDLE;
        evt_ext   = state == ST_EXT || state == ST_EXT_BRK;
        evt_brk   = state == ST_BRK || state == ST_EXT_BRK;
        evt_code  = scan_code;
    end
endmodule

// File: rtl/player_move_cmd_gen.sv
// player_move_cmd_gen: scan bytes -> held movement keys -> tick-divided forward/rotate strobes
// Optional PLAYER_MOVE_IDLE_CLR_EN clears held keys after IDLE_TICKS ticks without scan bytes.
module player_move_cmd_gen
    import player_input_pkg::*;
#(
    parameter int TICK_DIV = 1
`ifdef PLAYER_MOVE_IDLE_CLR_EN
    , parameter int IDLE_TICKS = 600
`endif
)(
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    input  logic       tick,
    output logic       forward,
    output logic       rotate,
    output logic       rotate_ccw,
    output logic [2:0] keys_held
);
    logic       evt_valid, evt_ext, evt_brk, fire, clr;
    logic [7:0] evt_code, div_cnt;
    logic [2:0] held, held_nxt, hit;
    player_key_decoder u_dec (
        .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_valid(scan_valid),
        .evt_valid(evt_valid), .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_code(evt_code)
    );
`ifdef PLAYER_MOVE_IDLE_CLR_EN
    localparam int IW = $clog2(IDLE_TICKS + 1);
    logic [IW-1:0] idle_cnt;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn)
            idle_cnt <= '0;
        else if (scan_valid)
            idle_cnt <= '0;
        else if (tick && idle_cnt != IW'(IDLE_TICKS))
            idle_cnt <= idle_cnt + 1'b1;
    assign clr = !scan_valid && idle_cnt == IW'(IDLE_TICKS) && |held;
`else
    assign clr = 1'b0;
`endif
    assign hit      = key_mask(evt_ext, evt_code);
    assign fire     = tick && div_cnt == 8'(TICK_DIV - 1);
    assign held_nxt = clr ? 3'b000 : !evt_valid ? held : evt_brk ? held & ~hit : held | hit;
    // Strobes sample held before this cycle's byte lands
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            held       <= '0;
            div_cnt    <= '0;
            forward    <= 1'b0;
            rotate     <= 1'b0;
            rotate_ccw <= 1'b0;
        end else begin
            held       <= held_nxt;
            div_cnt    <= tick ? (fire ? 8'd0 : div_cnt + 8'd1) : div_cnt;
            forward    <= fire & held[KEY_FWD];
            rotate     <= fire & (held[KEY_ROTL] ^ held[KEY_ROTR]);
            rotate_ccw <= fire & held[KEY_ROTL] & ~held[KEY_ROTR];
        end
    assign keys_held = held;
endmodule
